// File: rtl/sync_debounce.sv
// sync_debounce: per-channel STAGES-flop synchroniser and DEB_CYCLES debounce filter; clk/reset(async high), data_in -> data_out, rise/fall pulses, any_change
module sync_debounce #(
    parameter int WIDTH = 1,
    parameter int STAGES = 2,
    parameter int DEB_CYCLES = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);
    localparam int CW = ($clog2(DEB_CYCLES + 1) < 1) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(DEB_CYCLES - 1);
    if (STAGES < 2 || STAGES > 4 || DEB_CYCLES < 1) begin : g_bad_cfg
        $error("sync_debounce: STAGES must be 2..4 and DEB_CYCLES >= 1");
    end
    logic [WIDTH-1:0] stage [STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] flip;
    logic [CW-1:0] cnt [WIDTH];
    logic [CW-1:0] cnt_nxt [WIDTH];
    assign sync = stage[STAGES-1];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < STAGES; j++) stage[j] <= RST_VAL;
        end else begin
            stage[0] <= data_in;
            for (int j = 1; j < STAGES; j++) stage[j] <= stage[j-1];
        end
    end
    always_comb begin
        for (int c = 0; c < WIDTH; c++) begin
            flip[c] = (sync[c] != data_out[c]) && (cnt[c] == TERM);
            cnt_nxt[c] = (sync[c] == data_out[c] || flip[c]) ? '0 : cnt[c] + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RST_VAL;
            rise <= '0;
            fall <= '0;
            any_change <= 1'b0;
            for (int c = 0; c < WIDTH; c++) cnt[c] <= '0;
        end else begin
            data_out <= data_out ^ flip;
            rise <= flip & sync;
            fall <= flip & ~sync;
            any_change <= |flip;
            for (int c = 0; c < WIDTH; c++) cnt[c] <= cnt_nxt[c];
        end
    end
endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: table, directed corner and random model checks of sync_debounce
module tb_sync_debounce;
    localparam int S_A = 2;
    localparam int D_A = 4;
    localparam logic [3:0] RA = 4'b1010;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    logic [3:0] din_a = '0, out_a, rise_a, fall_a;
    logic any_a;
    logic [3:0] din_b = '0, out_b, rise_b, fall_b;
    logic any_b;
    logic din_c = 1'b0, out_c, rise_c, fall_c, any_c;
    logic din_d = 1'b0, out_d, rise_d, fall_d, any_d;
    sync_debounce #(.WIDTH(4), .STAGES(S_A), .DEB_CYCLES(D_A), .RST_VAL(RA)) u_a (
        .clk(clk), .reset(reset), .data_in(din_a), .data_out(out_a),
        .rise(rise_a), .fall(fall_a), .any_change(any_a));
    sync_debounce #(.WIDTH(4), .STAGES(2), .DEB_CYCLES(8), .RST_VAL(4'b0000)) u_b (
        .clk(clk), .reset(reset), .data_in(din_b), .data_out(out_b),
        .rise(rise_b), .fall(fall_b), .any_change(any_b));
    sync_debounce #(.WIDTH(1), .STAGES(4), .DEB_CYCLES(1), .RST_VAL(1'b0)) u_c (
        .clk(clk), .reset(reset), .data_in(din_c), .data_out(out_c),
        .rise(rise_c), .fall(fall_c), .any_change(any_c));
    sync_debounce #(.WIDTH(1), .STAGES(2), .DEB_CYCLES(65535), .RST_VAL(1'b0)) u_d (
        .clk(clk), .reset(reset), .data_in(din_d), .data_out(out_d),
        .rise(rise_d), .fall(fall_d), .any_change(any_d));
    int n_chk = 0;
    int n_fail = 0;
    typedef struct {
        logic [3:0] din;
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } vec_t;
    vec_t tbl [14] = '{
        '{4'b0000, 4'b1010, 4'b0000, 4'b0000, 1'b0},
        '{4'b0000, 4'b1010, 4'b0000, 4'b0000, 1'b0},
        '{4'b0000, 4'b1010, 4'b0000, 4'b0000, 1'b0},
        '{4'b0000, 4'b1010, 4'b0000, 4'b0000, 1'b0},
        '{4'b0000, 4'b1010, 4'b0000, 4'b0000, 1'b0},
        '{4'b0000, 4'b0000, 4'b0000, 4'b1010, 1'b1},
        '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0},
        '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0},
        '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0},
        '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0},
        '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0},
        '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0},
        '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1},
        '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0}
    };
    logic [3:0] hist [$];
    logic [3:0] m_out, m_rise, m_fall;
    logic m_any;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        hist.delete();
        repeat (S_A + D_A + 1) hist.push_back(RA);
        m_out = RA;
        m_rise = '0;
        m_fall = '0;
        m_any = 1'b0;
    endtask
    task automatic model_step(input logic [3:0] d);
        int n;
        logic [3:0] flip;
        hist.push_back(d);
        if (hist.size() > 16) hist.delete(0);
        n = hist.size();
        flip = '1;
        for (int j = 0; j < D_A; j++) flip &= hist[n-1-S_A-j] ^ m_out;
        m_rise = flip & ~m_out;
        m_fall = flip & m_out;
        m_any = |flip;
        m_out = m_out ^ flip;
    endtask
    initial begin
        int n, rs, fs, hi, first, first_out, anys, f3;
        logic [3:0] rise_at, fall_at;
        logic found, rise_seen;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din_a = 4'($urandom);
            tick();
            check("rst_out", 32'(out_a), 32'(RA));
            check("rst_rise", 32'(rise_a), 0);
            check("rst_fall", 32'(fall_a), 0);
            check("rst_any", 32'(any_a), 0);
        end
        din_a = RA;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            din_a = tbl[i].din;
            tick();
            check($sformatf("tbl%0d_out", i), 32'(out_a), 32'(tbl[i].dout));
            check($sformatf("tbl%0d_rise", i), 32'(rise_a), 32'(tbl[i].rise));
            check($sformatf("tbl%0d_fall", i), 32'(fall_a), 32'(tbl[i].fall));
            check($sformatf("tbl%0d_any", i), 32'(any_a), 32'(tbl[i].any));
        end
        din_a = 4'b0000;
        repeat (4) tick();
        check("midcnt_out", 32'(out_a), 32'(4'b0001));
        #2 reset = 1'b1;
        #1;
        check("async_rst_out", 32'(out_a), 32'(RA));
        check("async_rst_any", 32'(any_a), 0);
        tick();
        reset = 1'b0;
        n = 0;
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            tick();
            if (out_a == 4'b0000) begin
                found = 1'b1;
                n = k;
            end
        end
        check("rst_restart_lat", n, 6);
        for (int len = 3; len <= 4; len++) begin
            rs = 0;
            fs = 0;
            hi = 0;
            for (int k = 0; k < 16; k++) begin
                din_a[1] = (k < len);
                tick();
                rs += int'(rise_a[1]);
                fs += int'(fall_a[1]);
                hi += int'(out_a[1]);
            end
            check($sformatf("glitch%0d_rise", len), rs, (len == 4) ? 1 : 0);
            check($sformatf("glitch%0d_fall", len), fs, (len == 4) ? 1 : 0);
            check($sformatf("glitch%0d_high", len), hi, (len == 4) ? 4 : 0);
            check($sformatf("glitch%0d_end", len), 32'(out_a), 0);
        end
        din_a = 4'b0101;
        anys = 0;
        f3 = 0;
        rise_at = '0;
        fall_at = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (any_a) begin
                anys++;
                rise_at = rise_a;
                fall_at = fall_a;
            end
            f3 += int'(out_a[3]);
        end
        check("simul_any_cnt", anys, 1);
        check("simul_rise", 32'(rise_at), 32'(4'b0101));
        check("simul_fall", 32'(fall_at), 0);
        check("simul_out", 32'(out_a), 32'(4'b0101));
        check("simul_ch3", f3, 0);
        rs = 0;
        fs = 0;
        first = 0;
        first_out = 0;
        for (int k = 1; k <= 30; k++) begin
            din_b[2] = !(k == 2 || k == 5);
            tick();
            if (rise_b[2]) begin
                rs++;
                if (first == 0) first = k;
            end
            if (out_b[2] && first_out == 0) first_out = k;
            fs += int'(|fall_b);
        end
        check("bounce_rise_edge", first, 15);
        check("bounce_out_edge", first_out, 15);
        check("bounce_rise_cnt", rs, 1);
        check("bounce_fall_cnt", fs, 0);
        check("bounce_others", 32'(out_b), 32'(4'b0100));
        for (int k = 1; k <= 10; k++) begin
            din_c = (k == 1);
            tick();
            check($sformatf("deb1_out_e%0d", k), 32'(out_c), 32'(k == 5));
            check($sformatf("deb1_rise_e%0d", k), 32'(rise_c), 32'(k == 5));
            check($sformatf("deb1_fall_e%0d", k), 32'(fall_c), 32'(k == 6));
        end
        din_d = 1'b1;
        n = 0;
        found = 1'b0;
        rise_seen = 1'b0;
        for (int k = 1; k <= 70000 && !found; k++) begin
            tick();
            if (out_d) begin
                found = 1'b1;
                n = k;
                rise_seen = rise_d;
            end
        end
        check("deb65535_edge", n, 65537);
        check("deb65535_rise", 32'(rise_seen), 1);
        reset = 1'b1;
        #1;
        model_reset();
        tick();
        din_a = 4'($urandom);
        reset = 1'b0;
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) din_a[b] = ~din_a[b];
            @(posedge clk);
            model_step(din_a);
            #1;
            check("rand_out", 32'(out_a), 32'(m_out));
            check("rand_rise", 32'(rise_a), 32'(m_rise));
            check("rand_fall", 32'(fall_a), 32'(m_fall));
            check("rand_any", 32'(any_a), 32'(m_any));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
